// File: rtl/fst_pkg.sv
// Shared constants and FSM state encoding for the write-buffered memory.
package fst_pkg;

    localparam int DATA_W_DEF     = 16;
    localparam int ADDR_W_DEF     = 12;
    localparam int WBUF_DEPTH_DEF = 4;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/fst_wbuf.sv
// Write-buffer FIFO with a youngest-match forwarding lookup for reads.
module fst_wbuf
    import fst_pkg::*;
#(
    parameter int DATA_W     = DATA_W_DEF,
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int WBUF_DEPTH = WBUF_DEPTH_DEF,
    localparam int PTR_W     = $clog2(WBUF_DEPTH),
    localparam int CNT_W     = $clog2(WBUF_DEPTH + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic [ADDR_W-1:0] push_adr,
    input  logic [DATA_W-1:0] push_dat,
    input  logic              pop,
    input  logic [ADDR_W-1:0] lookup_adr,
    output logic [ADDR_W-1:0] head_adr,
    output logic [DATA_W-1:0] head_dat,
    output logic [CNT_W-1:0]  count,
    output logic              hit,
    output logic [DATA_W-1:0] hit_dat
);

    logic [ADDR_W-1:0] adr_q [WBUF_DEPTH];
    logic [DATA_W-1:0] dat_q [WBUF_DEPTH];
    logic [PTR_W-1:0]  head_q, tail_q;
    logic [CNT_W-1:0]  count_q;

    // Wraps explicitly so non-power-of-two depths stay in range.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(WBUF_DEPTH - 1)) return '0;
        return p + 1'b1;
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            if (push) tail_q <= ptr_inc(tail_q);
            if (pop)  head_q <= ptr_inc(head_q);
            count_q <= count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            adr_q[tail_q] <= push_adr;
            dat_q[tail_q] <= push_dat;
        end
    end

    // Walk oldest to youngest so the last match found is the newest write.
    always_comb begin
        logic [PTR_W-1:0] idx;
        hit     = 1'b0;
        hit_dat = '0;
        idx     = head_q;
        for (int i = 0; i < WBUF_DEPTH; i++) begin
            if (CNT_W'(i) < count_q && adr_q[idx] == lookup_adr) begin
                hit     = 1'b1;
                hit_dat = dat_q[idx];
            end
            idx = ptr_inc(idx);
        end
    end

    assign head_adr = adr_q[head_q];
    assign head_dat = dat_q[head_q];
    assign count    = count_q;

endmodule

// File: rtl/fst_mem_wbuf.sv
// Single-port word array fronted by a write buffer; reads take the port first,
// buffered writes drain in idle cycles, and a halt flushes the buffer.
module fst_mem_wbuf
    import fst_pkg::*;
#(
    parameter int DATA_W     = DATA_W_DEF,
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int WBUF_DEPTH = WBUF_DEPTH_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              read_en,
    input  logic [ADDR_W-1:0] read_adr,
    output logic [DATA_W-1:0] read_dat,
    output logic              read_valid,
    input  logic              write,
    input  logic [ADDR_W-1:0] write_adr,
    input  logic [DATA_W-1:0] write_dat,
    output logic              write_ready,
    input  logic              halt_req,
    output logic              drained,
    output logic              overflow
);

    localparam int CNT_W = $clog2(WBUF_DEPTH + 1);

    logic [DATA_W-1:0] mem [2**ADDR_W];
    state_t            state_q, state_nxt;
    logic [CNT_W-1:0]  count;
    logic [ADDR_W-1:0] head_adr;
    logic [DATA_W-1:0] head_dat;
    logic              hit;
    logic [DATA_W-1:0] hit_dat;
    logic              wr_acc, drain_en;
    logic [DATA_W-1:0] rd_src;

    assign write_ready = (count < CNT_W'(WBUF_DEPTH)) && (state_q == RUN);
    assign wr_acc      = write && write_ready && !reset;
    assign drain_en    = !read_en && (count != '0) && !reset;
    assign drained     = (state_q == DONE);

    fst_wbuf #(
        .DATA_W     (DATA_W),
        .ADDR_W     (ADDR_W),
        .WBUF_DEPTH (WBUF_DEPTH)
    ) u_wbuf (
        .clk        (clk),
        .reset      (reset),
        .push       (wr_acc),
        .push_adr   (write_adr),
        .push_dat   (write_dat),
        .pop        (drain_en),
        .lookup_adr (read_adr),
        .head_adr   (head_adr),
        .head_dat   (head_dat),
        .count      (count),
        .hit        (hit),
        .hit_dat    (hit_dat)
    );

    always_ff @(posedge clk) begin
        if (drain_en) mem[head_adr] <= head_dat;
    end

    always_comb begin
        state_nxt = state_q;
        case (state_q)
            RUN:     if (halt_req) state_nxt = DRAIN;
            DRAIN:   if (count == '0) state_nxt = DONE;
            DONE:    state_nxt = DONE;
            default: state_nxt = RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) state_q <= RUN;
        else       state_q <= state_nxt;
    end

    // Same-cycle write beats buffered data, which beats the array.
    always_comb begin
        rd_src = mem[read_adr];
        if (hit) rd_src = hit_dat;
        if (wr_acc && write_adr == read_adr) rd_src = write_dat;
    end

    // Read result register stage
    always_ff @(posedge clk) begin
        if (reset) begin
            read_valid <= 1'b0;
            read_dat   <= '0;
            overflow   <= 1'b0;
        end else begin
            read_valid <= read_en;
            if (read_en) read_dat <= rd_src;
            if (write && !write_ready) overflow <= 1'b1;
        end
    end

endmodule

// File: tb/tb_fst_mem_wbuf.sv
// Directed bench for fst_mem_wbuf: forwarding, overflow, halt/drain, reset, wrap.
module tb_fst_mem_wbuf;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, read_en, write, halt_req;
    logic [11:0] read_adr, write_adr;
    logic [15:0] write_dat, read_dat;
    logic        read_valid, write_ready, drained, overflow;

    logic        re3, w3, halt3;
    logic [11:0] ra3, wa3;
    logic [15:0] wd3, rd3;
    logic        rv3, wr3, dr3, ov3;

    int checks   = 0;
    int failures = 0;

    fst_mem_wbuf #(.DATA_W(16), .ADDR_W(12), .WBUF_DEPTH(4)) u_dut (
        .clk(clk), .reset(reset), .read_en(read_en), .read_adr(read_adr),
        .read_dat(read_dat), .read_valid(read_valid), .write(write),
        .write_adr(write_adr), .write_dat(write_dat), .write_ready(write_ready),
        .halt_req(halt_req), .drained(drained), .overflow(overflow)
    );

    fst_mem_wbuf #(.DATA_W(16), .ADDR_W(12), .WBUF_DEPTH(3)) u_dut3 (
        .clk(clk), .reset(reset), .read_en(re3), .read_adr(ra3),
        .read_dat(rd3), .read_valid(rv3), .write(w3),
        .write_adr(wa3), .write_dat(wd3), .write_ready(wr3),
        .halt_req(halt3), .drained(dr3), .overflow(ov3)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drv(input logic re, input logic [11:0] ra,
                       input logic we, input logic [11:0] wa, input logic [15:0] wd);
        read_en   = re;
        read_adr  = ra;
        write     = we;
        write_adr = wa;
        write_dat = wd;
    endtask

    task automatic idle(input int n);
        drv(1'b0, 12'h0, 1'b0, 12'h0, 16'h0);
        for (int k = 0; k < n; k++) step();
    endtask

    initial begin
        reset = 1'b1; halt_req = 1'b0;
        drv(1'b0, 12'h0, 1'b0, 12'h0, 16'h0);
        re3 = 1'b0; ra3 = '0; w3 = 1'b0; wa3 = '0; wd3 = '0; halt3 = 1'b0;
        step(); step();
        chk("rst_read_valid", 32'(read_valid), 32'd0);
        chk("rst_read_dat", 32'(read_dat), 32'h0);
        chk("rst_overflow", 32'(overflow), 32'd0);
        chk("rst_drained", 32'(drained), 32'd0);
        chk("rst_write_ready", 32'(write_ready), 32'd1);
        reset = 1'b0;

        // Buffered write forwarded to a read on the next cycle
        drv(1'b0, 12'h0, 1'b1, 12'h010, 16'hBEEF); step();
        drv(1'b1, 12'h010, 1'b0, 12'h0, 16'h0); step();
        chk("fwd_buf_valid", 32'(read_valid), 32'd1);
        chk("fwd_buf_dat", 32'(read_dat), 32'hBEEF);
        idle(1);
        chk("idle_valid", 32'(read_valid), 32'd0);
        chk("idle_hold_dat", 32'(read_dat), 32'hBEEF);
        drv(1'b1, 12'h010, 1'b0, 12'h0, 16'h0); step();
        chk("array_dat", 32'(read_dat), 32'hBEEF);
        idle(1);

        // Youngest buffer entry, then same-cycle write priority
        drv(1'b1, 12'h7FF, 1'b1, 12'h005, 16'h1111); step();
        drv(1'b1, 12'h7FF, 1'b1, 12'h005, 16'h2222); step();
        drv(1'b1, 12'h005, 1'b0, 12'h0, 16'h0); step();
        chk("youngest_dat", 32'(read_dat), 32'h2222);
        drv(1'b1, 12'h005, 1'b1, 12'h005, 16'h3333); step();
        chk("same_cycle_dat", 32'(read_dat), 32'h3333);
        idle(4);
        drv(1'b1, 12'h005, 1'b0, 12'h0, 16'h0); step();
        chk("drain_order_dat", 32'(read_dat), 32'h3333);

        // Fill under constant reads; the fifth write is dropped
        drv(1'b0, 12'h0, 1'b1, 12'h044, 16'h4444); step();
        idle(2);
        for (int i = 0; i < 5; i++) begin
            drv(1'b1, 12'h7FF, 1'b1, 12'h040 + 12'(i), 16'h4300 + 16'(i));
            chk($sformatf("fill_ready_%0d", i), 32'(write_ready), (i < 4) ? 32'd1 : 32'd0);
            step();
            if (i == 3) chk("ovf_before", 32'(overflow), 32'd0);
        end
        chk("ovf_set", 32'(overflow), 32'd1);
        idle(5);
        chk("ovf_sticky", 32'(overflow), 32'd1);
        chk("ready_after_drain", 32'(write_ready), 32'd1);
        drv(1'b1, 12'h044, 1'b0, 12'h0, 16'h0); step();
        chk("dropped_absent", 32'(read_dat), 32'h4444);
        drv(1'b1, 12'h043, 1'b0, 12'h0, 16'h0); step();
        chk("fourth_kept", 32'(read_dat), 32'h4303);

        // Reset while three writes are buffered
        for (int i = 0; i < 3; i++) begin
            drv(1'b0, 12'h0, 1'b1, 12'h050 + 12'(i), 16'h5000 + 16'(i)); step();
        end
        idle(2);
        for (int i = 0; i < 3; i++) begin
            drv(1'b1, 12'h7FF, 1'b1, 12'h050 + 12'(i), 16'h6000 + 16'(i)); step();
        end
        reset = 1'b1;
        drv(1'b1, 12'h050, 1'b1, 12'h050, 16'h6666); step();
        reset = 1'b0;
        chk("midrst_valid", 32'(read_valid), 32'd0);
        chk("midrst_dat", 32'(read_dat), 32'h0);
        chk("midrst_ready", 32'(write_ready), 32'd1);
        chk("midrst_ovf", 32'(overflow), 32'd0);
        idle(3);
        for (int i = 0; i < 3; i++) begin
            drv(1'b1, 12'h050 + 12'(i), 1'b0, 12'h0, 16'h0); step();
            chk($sformatf("midrst_arr_%0d", i), 32'(read_dat), 32'h5000 + 32'(i));
            chk($sformatf("midrst_rv_%0d", i), 32'(read_valid), 32'd1);
        end

        // Halt with three buffered writes and no reads
        for (int i = 0; i < 3; i++) begin
            drv(1'b1, 12'h7FF, 1'b1, 12'h060 + 12'(i), 16'h7000 + 16'(i)); step();
        end
        drv(1'b0, 12'h0, 1'b0, 12'h0, 16'h0);
        halt_req = 1'b1; step();
        halt_req = 1'b0;
        chk("drain_ready", 32'(write_ready), 32'd0);
        chk("drain_e1", 32'(drained), 32'd0);
        step(); step();
        chk("drain_e3", 32'(drained), 32'd0);
        step();
        chk("drain_e4", 32'(drained), 32'd1);
        for (int i = 0; i < 3; i++) begin
            drv(1'b1, 12'h060 + 12'(i), 1'b0, 12'h0, 16'h0); step();
            chk($sformatf("halt_arr_%0d", i), 32'(read_dat), 32'h7000 + 32'(i));
        end
        halt_req = 1'b1;
        drv(1'b0, 12'h0, 1'b1, 12'h061, 16'hDEAD);
        chk("done_ready", 32'(write_ready), 32'd0);
        step();
        halt_req = 1'b0;
        chk("done_held", 32'(drained), 32'd1);
        chk("done_ovf", 32'(overflow), 32'd1);
        drv(1'b1, 12'h061, 1'b0, 12'h0, 16'h0); step();
        chk("done_no_write", 32'(read_dat), 32'h7001);
        reset = 1'b1; idle(1); reset = 1'b0;
        chk("rst_clears_drained", 32'(drained), 32'd0);
        chk("rst_clears_ovf", 32'(overflow), 32'd0);

        // Depth-3 instance: pointer wrap with ordering preserved
        for (int i = 0; i < 10; i++) begin
            re3 = (i < 2); ra3 = 12'h7FF;
            w3 = 1'b1; wa3 = 12'h030 + 12'(i % 4); wd3 = 16'hA000 + 16'(i);
            chk($sformatf("wrap_ready_%0d", i), 32'(wr3), 32'd1);
            step();
        end
        re3 = 1'b0; w3 = 1'b0;
        for (int k = 0; k < 3; k++) step();
        for (int i = 0; i < 4; i++) begin
            re3 = 1'b1; ra3 = 12'h030 + 12'(i); step();
            chk($sformatf("wrap_arr_%0d", i), 32'(rd3),
                (i < 2) ? 32'hA008 + 32'(i) : 32'hA004 + 32'(i));
        end
        re3 = 1'b0;
        chk("wrap_ovf", 32'(ov3), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
